game_state_controller: RTL and testbench

Top-level game sequencer. Replaces the constant game state currently driving the renderer.
- Runs the attract/play/pause/death/game-over/win state machine from keyboard and collision events.
- Gates the 25 Hz game tick into the physics block and issues a physics re-spawn pulse.
- Presents a frame-synchronous game_state to the renderer.

---
 rtl/game_state_controller.sv | 167 ++++++++++++++++
 tb/tb_game_state_controller.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Game sequencer: attract/play/pause/death/game-over/win FSM, gated physics
// tick, respawn pulse and a frame-synchronous state code for the renderer.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   game_tick    one-cycle pulse per game frame
//   frame_start  one-cycle pulse at start of vertical blank
//   pause, jump  synchronised key levels (rising edges are the events)
//   player_hit   hazard collision (level or pulse)
//   level_done   goal reached (level or pulse)
//   game_state   state code, updated only on frame_start
//   phys_tick    game_tick forwarded to physics while playing
//   phys_respawn one-cycle pulse: physics reloads the spawn position
//   lives        remaining lives
//
// Optional feature macro: TICK_STEP_EN (jump in PAUSED single-steps physics).

`timescale 1ns/1ps

module game_state_controller #(
    parameter int LIVES       = 3,
    parameter int DEATH_TICKS = 50,
    parameter int END_TIMEOUT = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       frame_start,
    input  logic       pause,
    input  logic       jump,
    input  logic       player_hit,
    input  logic       level_done,
    output logic [3:0] game_state,
    output logic       phys_tick,
    output logic       phys_respawn,
    output logic [1:0] lives
);

    typedef enum logic [3:0] {
        S_ATTRACT   = 4'h0,
        S_PLAY      = 4'h1,
        S_PAUSED    = 4'h2,
        S_DYING     = 4'h3,
        S_GAME_OVER = 4'h4,
        S_WIN       = 4'h5
    } state_t;

    localparam logic [7:0] DEATH_LAST = 8'(DEATH_TICKS - 1);
    localparam logic [7:0] END_LAST   = 8'(END_TIMEOUT - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [1:0] lives_q, lives_d;
    logic       respawn_q, respawn_d;
    logic       tick_q, tick_d;
    logic [3:0] disp_q, disp_d;
    logic       pause_q, jump_q;
    logic       pause_rise, jump_rise;
    logic       step;

    assign pause_rise = pause & ~pause_q;
    assign jump_rise  = jump & ~jump_q;

`ifdef TICK_STEP_EN
    assign step = (state_q == S_PAUSED) & jump_rise;
`else
    assign step = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ATTRACT;
            count_q   <= 8'd0;
            lives_q   <= 2'd0;
            respawn_q <= 1'b0;
            tick_q    <= 1'b0;
            disp_q    <= 4'h0;
            pause_q   <= 1'b0;
            jump_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lives_q   <= lives_d;
            respawn_q <= respawn_d;
            tick_q    <= tick_d;
            disp_q    <= disp_d;
            pause_q   <= pause;
            jump_q    <= jump;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ATTRACT: begin
                if (jump_rise)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                if (player_hit)
                    state_d = S_DYING;
                else if (level_done)
                    state_d = S_WIN;
                else if (pause_rise)
                    state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (pause_rise)
                    state_d = S_PLAY;
            end
            S_DYING: begin
                if (game_tick && count_q == DEATH_LAST) begin
                    if (lives_q <= 2'd1)
                        state_d = S_GAME_OVER;
                    else
                        state_d = S_PLAY;
                end
            end
            S_GAME_OVER, S_WIN: begin
                if (jump_rise)
                    state_d = S_ATTRACT;
                else if (game_tick && count_q == END_LAST)
                    state_d = S_ATTRACT;
            end
            default: state_d = S_ATTRACT;
        endcase
    end

    // Outputs and datapath updates derived from the transition
    always_comb begin
        count_d   = count_q;
        lives_d   = lives_q;
        respawn_d = 1'b0;
        // Uses pre-transition state: a tick on the pause edge still goes out
        tick_d    = (game_tick & (state_q == S_PLAY)) | step;
        disp_d    = frame_start ? 4'(state_q) : disp_q;

        if (state_d != state_q) begin
            count_d = 8'd0;
        end else if (game_tick && (state_q == S_DYING ||
                                   state_q == S_GAME_OVER ||
                                   state_q == S_WIN)) begin
            count_d = count_q + 8'd1;
        end

        if (state_q == S_ATTRACT && state_d == S_PLAY) begin
            lives_d   = LIVES_INIT;
            respawn_d = 1'b1;
        end else if (state_q == S_DYING && state_d != S_DYING) begin
            // Last life saturates to 0 on the way to GAME_OVER
            lives_d   = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            respawn_d = (state_d == S_PLAY);
        end else if (state_d == S_ATTRACT && state_q != S_ATTRACT) begin
            lives_d = 2'd0;
        end
    end

    assign game_state   = disp_q;
    assign phys_tick    = tick_q;
    assign phys_respawn = respawn_q;
    assign lives        = lives_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed testbench for game_state_controller.
// Drives inputs 1 ns after each rising edge and samples there too.

`timescale 1ns/1ps

module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_tick = 1'b0;
    logic       frame_start = 1'b0;
    logic       pause = 1'b0;
    logic       jump = 1'b0;
    logic       player_hit = 1'b0;
    logic       level_done = 1'b0;
    logic [3:0] game_state;
    logic       phys_tick;
    logic       phys_respawn;
    logic [1:0] lives;

    int checks = 0;
    int failures = 0;

`ifdef TICK_STEP_EN
    localparam int STEP_EXP = 1;
`else
    localparam int STEP_EXP = 0;
`endif

    game_state_controller dut (
        .clk          (clk),
        .rst          (rst),
        .game_tick    (game_tick),
        .frame_start  (frame_start),
        .pause        (pause),
        .jump         (jump),
        .player_hit   (player_hit),
        .level_done   (level_done),
        .game_state   (game_state),
        .phys_tick    (phys_tick),
        .phys_respawn (phys_respawn),
        .lives        (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if (game_state !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", game_state);
        end
        checks++;
        if (lives !== 2'd0) begin
            failures++;
            $display("FAIL reset_lives got=%0d exp=0", lives);
        end
        checks++;
        if (phys_tick !== 1'b0 || phys_respawn !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b%b exp=00",
                     phys_tick, phys_respawn);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        checks++;
        if (phys_respawn !== 1'b1 || lives !== 2'd3) begin
            failures++;
            $display("FAIL start got respawn=%b lives=%0d exp 1/3",
                     phys_respawn, lives);
        end
        checks++;
        if (game_state !== 4'h0) begin
            failures++;
            $display("FAIL start_no_frame got=%h exp=0", game_state);
        end
        cyc();
        checks++;
        if (phys_respawn !== 1'b0) begin
            failures++;
            $display("FAIL start_pulse_len got=%b exp=0", phys_respawn);
        end
        frame();
        checks++;
        if (game_state !== 4'h1) begin
            failures++;
            $display("FAIL start_frame got=%h exp=1", game_state);
        end
    endtask

    task automatic test_play_tick();
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            if (phys_tick === 1'b1) n++;
            cyc();
            if (phys_tick !== 1'b0) n += 10;
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL play_ticks got=%0d exp=5", n);
        end
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            if (phys_tick !== 1'b0) n++;
            cyc();
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL paused_ticks got=%0d exp=0", n);
        end
        frame();
        checks++;
        if (game_state !== 4'h2) begin
            failures++;
            $display("FAIL paused_state got=%h exp=2", game_state);
        end
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        cyc();
        // tick on the same cycle as the pause edge is still forwarded
        pause = 1'b1;
        game_tick = 1'b1;
        cyc();
        pause = 1'b0;
        game_tick = 1'b0;
        checks++;
        if (phys_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_on_pause got=%b exp=1", phys_tick);
        end
        frame();
        checks++;
        if (game_state !== 4'h2) begin
            failures++;
            $display("FAIL pause_again got=%h exp=2", game_state);
        end
    endtask

    task automatic test_step();
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            jump = 1'b1;
            cyc();
            jump = 1'b0;
            if (phys_tick === 1'b1) n++;
            cyc();
            if (phys_tick !== 1'b0) n += 10;
        end
        checks++;
        if (n !== 3 * STEP_EXP) begin
            failures++;
            $display("FAIL step_pulses got=%0d exp=%0d", n, 3 * STEP_EXP);
        end
        player_hit = 1'b1;
        level_done = 1'b1;
        cyc();
        player_hit = 1'b0;
        level_done = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h2) begin
            failures++;
            $display("FAIL step_stays_paused got=%h exp=2", game_state);
        end
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h1) begin
            failures++;
            $display("FAIL unpause got=%h exp=1", game_state);
        end
    endtask

    task automatic test_death();
        int bad;
        bad = 0;
        player_hit = 1'b1;
        pause = 1'b1;
        cyc();
        player_hit = 1'b0;
        pause = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h3) begin
            failures++;
            $display("FAIL dying_state got=%h exp=3", game_state);
        end
        for (int i = 0; i < 49; i++) begin
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            if (phys_tick !== 1'b0 || phys_respawn !== 1'b0) bad++;
            cyc();
        end
        checks++;
        if (bad !== 0 || lives !== 2'd3) begin
            failures++;
            $display("FAIL dying_49 got bad=%0d lives=%0d exp 0/3",
                     bad, lives);
        end
        game_tick = 1'b1;
        cyc();
        game_tick = 1'b0;
        checks++;
        if (phys_respawn !== 1'b1 || lives !== 2'd2) begin
            failures++;
            $display("FAIL dying_50 got respawn=%b lives=%0d exp 1/2",
                     phys_respawn, lives);
        end
        frame();
        checks++;
        if (game_state !== 4'h1 || phys_respawn !== 1'b0) begin
            failures++;
            $display("FAIL respawn_play got=%h/%b exp=1/0",
                     game_state, phys_respawn);
        end
    endtask

    task automatic test_game_over();
        logic [1:0] exp_l;
        logic       exp_r;
        for (int d = 0; d < 2; d++) begin
            player_hit = 1'b1;
            cyc();
            player_hit = 1'b0;
            for (int i = 0; i < 49; i++) begin
                game_tick = 1'b1;
                cyc();
                game_tick = 1'b0;
                cyc();
            end
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            exp_l = (d == 0) ? 2'd1 : 2'd0;
            exp_r = (d == 0) ? 1'b1 : 1'b0;
            checks++;
            if (lives !== exp_l || phys_respawn !== exp_r) begin
                failures++;
                $display("FAIL death%0d got lives=%0d rsp=%b exp %0d/%b",
                         d, lives, phys_respawn, exp_l, exp_r);
            end
        end
        frame();
        checks++;
        if (game_state !== 4'h4) begin
            failures++;
            $display("FAIL game_over got=%h exp=4", game_state);
        end
        for (int i = 0; i < 249; i++) begin
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            cyc();
        end
        frame();
        checks++;
        if (game_state !== 4'h4) begin
            failures++;
            $display("FAIL timeout_249 got=%h exp=4", game_state);
        end
        // timeout and frame_start coincide: display keeps old state
        game_tick = 1'b1;
        frame_start = 1'b1;
        cyc();
        game_tick = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (game_state !== 4'h4) begin
            failures++;
            $display("FAIL timeout_same_frame got=%h exp=4", game_state);
        end
        frame();
        checks++;
        if (game_state !== 4'h0 || lives !== 2'd0) begin
            failures++;
            $display("FAIL timeout_attract got=%h lives=%0d exp 0/0",
                     game_state, lives);
        end
    endtask

    task automatic test_win();
        jump = 1'b1;
        cyc();
        level_done = 1'b1;
        cyc();
        level_done = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h5 || lives !== 2'd3) begin
            failures++;
            $display("FAIL win got=%h lives=%0d exp 5/3", game_state, lives);
        end
        cyc();
        cyc();
        cyc();
        frame();
        checks++;
        if (game_state !== 4'h5) begin
            failures++;
            $display("FAIL win_held_jump got=%h exp=5", game_state);
        end
        jump = 1'b0;
        cyc();
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h0 || lives !== 2'd0) begin
            failures++;
            $display("FAIL win_exit got=%h lives=%0d exp 0/0",
                     game_state, lives);
        end
    endtask

    task automatic test_reset_mid();
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        frame();
        checks++;
        if (game_state !== 4'h1 || lives !== 2'd3) begin
            failures++;
            $display("FAIL restart got=%h lives=%0d exp 1/3",
                     game_state, lives);
        end
        jump = 1'b1;
        cyc();
        jump = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (game_state !== 4'h0 || lives !== 2'd0 ||
            phys_respawn !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h lives=%0d rsp=%b exp 0/0/0",
                     game_state, lives, phys_respawn);
        end
        cyc();
        rst = 1'b1;
        cyc();
        frame();
        checks++;
        if (game_state !== 4'h0 || phys_respawn !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%h rsp=%b exp 0/0",
                     game_state, phys_respawn);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_play_tick();
        test_step();
        test_death();
        test_game_over();
        test_win();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
